door_access_controller: RTL and testbench

DOOR_ACCESS_CONTROLLER -- requirements
Module: door_access_controller

---
 rtl/door_access_controller.sv | 274 +++++++++++++++++++++++++++
 tb/tb_door_access_controller.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/door_access_controller.sv
// Keypad door-access controller: per-user numeric passwords, retry lockout and
// in-session password change. All outputs come straight from flops.
module door_access_controller #(
    parameter int NUM_USERS    = 10,
    parameter int NUM_DIGITS   = 4,
    parameter int MAX_FAIL     = 3,
    parameter int LOCK_CYCLES  = 1000,
    parameter int GRANT_CYCLES = 500
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] digit_in,
    input  logic       digit_valid,
    input  logic       enter,
    input  logic       change,
    input  logic       cancel,
    output logic       unlock,
    output logic       deny,
    output logic       locked,
    output logic [3:0] user_id,
    output logic [3:0] digit_count,
    output logic       pw_changed
);

    localparam int BW   = 4 * NUM_DIGITS;
    localparam int TMAX = (LOCK_CYCLES > GRANT_CYCLES) ? LOCK_CYCLES : GRANT_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [TW-1:0] GRANT_LAST = TW'(GRANT_CYCLES - 1);
    localparam logic [TW-1:0] LOCK_LAST  = TW'(LOCK_CYCLES - 1);
    localparam logic [3:0]    FULL_CNT   = 4'(NUM_DIGITS);
    localparam logic [3:0]    FAIL_LIM   = 4'(MAX_FAIL);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_ENTRY       = 3'd1,
        S_CHECK       = 3'd2,
        S_GRANT       = 3'd3,
        S_DENY        = 3'd4,
        S_LOCKOUT     = 3'd5,
        S_CHG_NEW     = 3'd6,
        S_CHG_CONFIRM = 3'd7
    } state_t;

    // Factory password of a 1-based slot: every digit equals (slot mod 10).
    function automatic logic [BW-1:0] default_pw(input int slot);
        logic [BW-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            v[4*i +: 4] = 4'(slot % 10);
        end
        return v;
    endfunction

    state_t        state_q, state_d;
    logic [BW-1:0] entry_q, entry_d;
    logic [BW-1:0] tmp_q, tmp_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [3:0]    fail_q, fail_d;
    logic [3:0]    uid_q, uid_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [BW-1:0] pw_q [NUM_USERS];
    logic          unlock_q, deny_q, locked_q, pwc_q, pwc_d;
    logic          wr_en_s;
    logic          match_s;
    logic [3:0]    match_id_s;
    logic          digit_ok_s;
    logic          full_s;
    logic [BW-1:0] shifted_s;

    // Parallel compare of the entry buffer against every slot; lowest index wins.
    always_comb begin
        match_s    = 1'b0;
        match_id_s = 4'd0;
        for (int k = NUM_USERS - 1; k >= 0; k--) begin
            if (pw_q[k] == entry_q) begin
                match_s    = 1'b1;
                match_id_s = 4'(k + 1);
            end else begin
                match_s    = match_s;
            end
        end
    end

    // Keypad qualification and the buffer image after shifting in the new digit.
    always_comb begin
        digit_ok_s = digit_valid && (digit_in <= 4'd9) && (cnt_q < FULL_CNT);
        full_s     = (cnt_q == FULL_CNT);
        shifted_s  = (entry_q << 4) | BW'(digit_in);
    end

    // Next-state and datapath update; enter beats digit, cancel beats enter.
    always_comb begin
        state_d = state_q;
        entry_d = entry_q;
        tmp_d   = tmp_q;
        cnt_d   = cnt_q;
        fail_d  = fail_q;
        uid_d   = uid_q;
        tmr_d   = tmr_q;
        wr_en_s = 1'b0;
        pwc_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (digit_ok_s) begin
                    entry_d = shifted_s;
                    cnt_d   = cnt_q + 4'd1;
                    state_d = S_ENTRY;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ENTRY: begin
                if (cancel) begin
                    state_d = S_IDLE;
                end else if (enter) begin
                    if (full_s) begin
                        state_d = S_CHECK;
                    end else begin
                        fail_d  = fail_q + 4'd1;
                        state_d = S_DENY;
                    end
                end else if (digit_ok_s) begin
                    entry_d = shifted_s;
                    cnt_d   = cnt_q + 4'd1;
                end else begin
                    state_d = S_ENTRY;
                end
            end
            S_CHECK: begin
                entry_d = '0;
                cnt_d   = 4'd0;
                if (match_s) begin
                    uid_d   = match_id_s;
                    fail_d  = 4'd0;
                    tmr_d   = '0;
                    state_d = S_GRANT;
                end else begin
                    fail_d  = fail_q + 4'd1;
                    state_d = S_DENY;
                end
            end
            S_GRANT: begin
                if (change) begin
                    entry_d = '0;
                    cnt_d   = 4'd0;
                    state_d = S_CHG_NEW;
                end else if (tmr_q == GRANT_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            S_DENY: begin
                if (fail_q >= FAIL_LIM) begin
                    tmr_d   = '0;
                    state_d = S_LOCKOUT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOCKOUT: begin
                if (tmr_q == LOCK_LAST) begin
                    fail_d  = 4'd0;
                    state_d = S_IDLE;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            S_CHG_NEW: begin
                if (cancel) begin
                    state_d = S_IDLE;
                end else if (enter) begin
                    if (full_s) begin
                        tmp_d   = entry_q;
                        entry_d = '0;
                        cnt_d   = 4'd0;
                        state_d = S_CHG_CONFIRM;
                    end else begin
                        state_d = S_DENY;
                    end
                end else if (digit_ok_s) begin
                    entry_d = shifted_s;
                    cnt_d   = cnt_q + 4'd1;
                end else begin
                    state_d = S_CHG_NEW;
                end
            end
            S_CHG_CONFIRM: begin
                if (cancel) begin
                    state_d = S_IDLE;
                end else if (enter) begin
                    if (full_s && (entry_q == tmp_q)) begin
                        wr_en_s = 1'b1;
                        pwc_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DENY;
                    end
                end else if (digit_ok_s) begin
                    entry_d = shifted_s;
                    cnt_d   = cnt_q + 4'd1;
                end else begin
                    state_d = S_CHG_CONFIRM;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Any return to IDLE wipes the session context.
        if (state_d == S_IDLE) begin
            entry_d = '0;
            cnt_d   = 4'd0;
            uid_d   = 4'd0;
        end else begin
            uid_d   = uid_d;
        end
    end

    // Password slots: factory values on reset, committed change otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_USERS; k++) begin
                pw_q[k] <= default_pw(k + 1);
            end
        end else begin
            for (int k = 0; k < NUM_USERS; k++) begin
                if (wr_en_s && (uid_q == 4'(k + 1))) begin
                    pw_q[k] <= tmp_q;
                end
            end
        end
    end

    // Control state, datapath registers and flop-driven outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            entry_q  <= '0;
            tmp_q    <= '0;
            cnt_q    <= 4'd0;
            fail_q   <= 4'd0;
            uid_q    <= 4'd0;
            tmr_q    <= '0;
            unlock_q <= 1'b0;
            deny_q   <= 1'b0;
            locked_q <= 1'b0;
            pwc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            entry_q  <= entry_d;
            tmp_q    <= tmp_d;
            cnt_q    <= cnt_d;
            fail_q   <= fail_d;
            uid_q    <= uid_d;
            tmr_q    <= tmr_d;
            unlock_q <= (state_d == S_GRANT);
            deny_q   <= (state_d == S_DENY);
            locked_q <= (state_d == S_LOCKOUT);
            pwc_q    <= pwc_d;
        end
    end

    assign unlock      = unlock_q;
    assign deny        = deny_q;
    assign locked      = locked_q;
    assign pw_changed  = pwc_q;
    assign user_id     = uid_q;
    assign digit_count = cnt_q;

endmodule

// File: tb/tb_door_access_controller.sv
// Bench for door_access_controller: directed scenarios followed by randomized
// sessions, checked against a transaction-level model of users and retries.
module tb_door_access_controller;

    typedef int iq_t[$];

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] digit_in;
    logic       digit_valid, enter, change, cancel;
    logic       unlock, deny, locked, pw_changed;
    logic [3:0] user_id, digit_count;

    int n_checks = 0;
    int n_fail   = 0;
    int pw_m [1:10];
    int fail_m   = 0;

    door_access_controller dut (
        .clk(clk), .reset(reset), .digit_in(digit_in), .digit_valid(digit_valid),
        .enter(enter), .change(change), .cancel(cancel), .unlock(unlock),
        .deny(deny), .locked(locked), .user_id(user_id),
        .digit_count(digit_count), .pw_changed(pw_changed)
    );

    always #5 clk = ~clk;

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog: run exceeded time limit (failures so far %0d)", n_fail);
        $fatal(1, "watchdog expired");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic iq_t mkq(input int code, input int len);
        iq_t q;
        int p = 1;
        for (int i = 1; i < len; i++) p = p * 10;
        for (int i = 0; i < len; i++) begin
            q.push_back((code / p) % 10);
            p = p / 10;
        end
        return q;
    endfunction

    function automatic iq_t rand_digits(input int len);
        iq_t q;
        for (int i = 0; i < len; i++) q.push_back(int'($urandom_range(0, 9)));
        return q;
    endfunction

    function automatic void model_reset();
        for (int k = 1; k <= 10; k++) pw_m[k] = (k % 10) * 1111;
        fail_m = 0;
    endfunction

    function automatic int model_match(input int code);
        for (int k = 1; k <= 10; k++) if (pw_m[k] == code) return k;
        return 0;
    endfunction

    // Press keys one per cycle; code/n are the digits the keypad should accept.
    task automatic key_seq(input iq_t digs, output int code, output int n);
        code = 0;
        n = 0;
        foreach (digs[i]) begin
            digit_in = 4'(digs[i]);
            digit_valid = 1'b1;
            cyc();
            digit_valid = 1'b0;
            if (digs[i] <= 9 && n < 4) begin
                code = code * 10 + digs[i];
                n++;
            end
            check("digit_count", digit_count, n);
        end
    endtask

    task automatic lock_phase();
        int n = 0;
        while (locked === 1'b1 && n < 1200) begin
            n++;
            digit_in    = 4'($urandom_range(0, 15));
            digit_valid = 1'($urandom_range(0, 1));
            cancel      = 1'($urandom_range(0, 1));
            enter       = 1'($urandom_range(0, 1));
            change      = 1'($urandom_range(0, 1));
            cyc();
        end
        digit_valid = 1'b0; cancel = 1'b0; enter = 1'b0; change = 1'b0;
        check("lockout_len", n, 1000);
        check("lockout_keys_ignored", digit_count, 0);
        check("lockout_exit_quiet", {unlock, deny, locked}, 0);
        fail_m = 0;
    endtask

    task automatic grant_phase(input int k);
        int n = 0;
        int bad = 0;
        while (unlock === 1'b1 && n < 700) begin
            if (user_id !== 4'(k)) bad++;
            n++;
            cyc();
        end
        check("grant_len", n, 500);
        check("grant_uid_stable", bad, 0);
        check("grant_exit_uid", user_id, 0);
    endtask

    // One cycle after the deny pulse: either back to idle or into lockout.
    task automatic after_fail(input bit hold);
        fail_m++;
        cyc();
        check("deny_one_cycle", deny, 0);
        if (fail_m >= 3) begin
            check("lockout_entered", locked, 1);
            if (hold) lock_phase();
        end else begin
            check("no_lockout", locked, 0);
            check("idle_count_clear", digit_count, 0);
        end
    endtask

    // Login attempt; on a grant returns in the first unlocked cycle.
    task automatic attempt(input iq_t digs, input bit hold, output int res);
        int code, n;
        key_seq(digs, code, n);
        enter = 1'b1;
        cyc();
        enter = 1'b0;
        res = 0;
        if (n < 4) begin
            check("short_enter_deny", deny, 1);
            after_fail(hold);
        end else begin
            check("check_cycle_quiet", {unlock, deny, locked}, 0);
            cyc();
            res = model_match(code);
            if (res != 0) begin
                check("grant_unlock", unlock, 1);
                check("grant_uid", user_id, res);
                check("grant_no_deny", deny, 0);
                fail_m = 0;
            end else begin
                check("wrong_code_deny", deny, 1);
                check("wrong_code_locked", unlock, 0);
                after_fail(hold);
            end
        end
    endtask

    task automatic change_seq(input int k, input iq_t new_digs, input iq_t conf_digs);
        int c1, n1, c2, n2;
        change = 1'b1;
        cyc();
        change = 1'b0;
        check("chg_unlock_drop", unlock, 0);
        check("chg_uid_held", user_id, k);
        check("chg_count_clear", digit_count, 0);
        key_seq(new_digs, c1, n1);
        enter = 1'b1;
        cyc();
        enter = 1'b0;
        if (n1 < 4) begin
            check("chg_short_deny", deny, 1);
            cyc();
            check("chg_short_idle", user_id, 0);
            return;
        end
        check("chg_new_no_deny", deny, 0);
        check("chg_new_count_clear", digit_count, 0);
        key_seq(conf_digs, c2, n2);
        enter = 1'b1;
        cyc();
        enter = 1'b0;
        if (n2 == 4 && c2 == c1) begin
            check("chg_commit_pulse", pw_changed, 1);
            check("chg_commit_no_deny", deny, 0);
            pw_m[k] = c1;
        end else begin
            check("chg_confirm_deny", deny, 1);
            check("chg_confirm_no_commit", pw_changed, 0);
        end
        cyc();
        check("chg_end_pulses", {pw_changed, deny, locked}, 0);
        check("chg_end_uid", user_id, 0);
    endtask

    task automatic cancel_seq(input iq_t digs);
        int code, n;
        key_seq(digs, code, n);
        cancel = 1'b1;
        cyc();
        cancel = 1'b0;
        check("cancel_no_deny", deny, 0);
        check("cancel_count_clear", digit_count, 0);
        cyc();
        check("cancel_idle", {unlock, deny, locked}, 0);
    endtask

    task automatic async_reset_now();
        #2 reset = 1'b1;
        #1 check("async_reset_outputs", {unlock, deny, locked, pw_changed, user_id, digit_count}, 0);
        digit_valid = 1'b0; enter = 1'b0; change = 1'b0; cancel = 1'b0;
        cyc();
        reset = 1'b0;
        cyc();
        model_reset();
        check("post_reset_outputs", {unlock, deny, locked, pw_changed, user_id, digit_count}, 0);
    endtask

    initial begin : stim
        int res, code, n, u, kind;
        iq_t q, q2;
        reset = 1'b1; digit_in = 4'd0; digit_valid = 1'b0;
        enter = 1'b0; change = 1'b0; cancel = 1'b0;
        model_reset();
        cyc();
        cyc();
        check("reset_outputs_held", {unlock, deny, locked, pw_changed, user_id, digit_count}, 0);
        reset = 1'b0;
        cyc();
        check("reset_outputs_after", {unlock, deny, locked, pw_changed, user_id, digit_count}, 0);

        // Basic login of user 3 with the full hold time.
        attempt(mkq(3333, 4), 1'b1, res);
        check("login3_uid", user_id, 3);
        grant_phase(3);

        // Short entry denies; over-long entry saturates; cancel is silent.
        attempt(mkq(12, 2), 1'b1, res);
        key_seq(mkq(121212, 6), code, n);
        check("count_saturates", digit_count, 4);
        cancel = 1'b1;
        cyc();
        cancel = 1'b0;
        check("cancel_mid_entry_deny", deny, 0);
        check("cancel_mid_entry_count", digit_count, 0);

        // Failed confirm keeps the old password of user 2.
        attempt(mkq(2222, 4), 1'b0, res);
        check("login2_uid", user_id, 2);
        change_seq(2, mkq(5555, 4), mkq(5556, 4));
        attempt(mkq(2222, 4), 1'b0, res);
        check("user2_unchanged", user_id, 2);
        grant_phase(2);

        // Successful change of user 1 to 4242.
        attempt(mkq(1111, 4), 1'b0, res);
        check("login1_uid", user_id, 1);
        change_seq(1, mkq(4242, 4), mkq(4242, 4));
        attempt(mkq(4242, 4), 1'b0, res);
        check("new_pw_grants", user_id, 1);
        grant_phase(1);
        attempt(mkq(1111, 4), 1'b1, res);

        // enter beats a simultaneous digit; cancel beats a simultaneous enter.
        key_seq(mkq(123, 3), code, n);
        digit_in = 4'd4; digit_valid = 1'b1; enter = 1'b1;
        cyc();
        digit_valid = 1'b0; enter = 1'b0;
        check("enter_beats_digit", deny, 1);
        after_fail(1'b1);
        key_seq(mkq(5555, 4), code, n);
        enter = 1'b1; cancel = 1'b1;
        cyc();
        enter = 1'b0; cancel = 1'b0;
        check("cancel_beats_enter", deny, 0);
        check("cancel_beats_enter_count", digit_count, 0);
        cyc();
        check("cancel_beats_enter_idle", {unlock, deny}, 0);

        // Clear the fail count, then three wrong codes lock the keypad.
        attempt(mkq(4242, 4), 1'b0, res);
        grant_phase(res);
        for (int i = 0; i < 3; i++) attempt(mkq(9876, 4), 1'b1, res);

        // Randomized sessions.
        for (int it = 0; it < 30; it++) begin
            kind = $urandom_range(0, 9);
            if (kind <= 3) begin
                u = $urandom_range(1, 10);
                q = mkq(pw_m[u], 4);
                if ($urandom_range(0, 2) == 0)
                    q.insert($urandom_range(0, 4), int'($urandom_range(10, 15)));
                attempt(q, 1'b1, res);
                if (res != 0) begin
                    if ($urandom_range(0, 1) == 1) begin
                        code = $urandom_range(0, 9999);
                        q = mkq(code, 4);
                        q2 = mkq(($urandom_range(0, 1) == 1) ? code : (code + 1) % 10000, 4);
                        change_seq(res, q, q2);
                    end else begin
                        grant_phase(res);
                    end
                end
            end else if (kind <= 6) begin
                attempt(rand_digits(4), 1'b1, res);
                if (res != 0) grant_phase(res);
            end else if (kind == 7) begin
                attempt(rand_digits($urandom_range(1, 3)), 1'b1, res);
            end else if (kind == 8) begin
                attempt(rand_digits($urandom_range(5, 6)), 1'b1, res);
                if (res != 0) grant_phase(res);
            end else begin
                cancel_seq(rand_digits($urandom_range(1, 4)));
            end
        end

        // Reset in the middle of a lockout restores factory passwords.
        for (int i = 0; i < 3 && fail_m < 3; i++) attempt(mkq(9, 1), 1'b0, res);
        repeat (10) cyc();
        check("mid_lockout_locked", locked, 1);
        async_reset_now();
        attempt(mkq(1111, 4), 1'b0, res);
        check("default_pw_restored", user_id, 1);
        grant_phase(1);

        // Reset in the middle of a confirm step must not write the slot.
        attempt(mkq(7777, 4), 1'b0, res);
        check("login7_uid", user_id, 7);
        change = 1'b1;
        cyc();
        change = 1'b0;
        key_seq(mkq(1234, 4), code, n);
        enter = 1'b1;
        cyc();
        enter = 1'b0;
        key_seq(mkq(1234, 4), code, n);
        async_reset_now();
        attempt(mkq(1234, 4), 1'b1, res);
        attempt(mkq(7777, 4), 1'b0, res);
        check("slot7_kept", user_id, 7);
        grant_phase(7);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
